// File: rtl/mux_arb_pkg.sv
// Shared constants, output-register state encoding and the round-robin
// pointer increment used by the arbiter.
package mux_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;

  // Output register occupancy: EMPTY means out_valid=0, FULL means out_valid=1.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Pointer moves one past the last winner and wraps from n-1 back to 0,
  // so values >= n are never produced for non-power-of-two n.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr == n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: lowest valid index at or above ptr,
// otherwise lowest valid index overall. Done as a scan over a double-width
// vector whose low half is masked below ptr and whose high half is unmasked.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] grant,
  output logic             any
);

  logic [N_REQ-1:0]   masked;
  logic [2*N_REQ-1:0] dbl;
  int                 first_idx;
  logic               found;

  // Build the masked/unmasked double vector and find its lowest set bit.
  always_comb begin
    masked    = '0;
    found     = 1'b0;
    first_idx = 0;
    for (int i = 0; i < N_REQ; i++) begin
      masked[i] = req_valid[i] && (i >= int'(ptr));
    end
    dbl = {req_valid, masked};
    for (int j = 0; j < 2 * N_REQ; j++) begin
      if (!found && dbl[j]) begin
        found     = 1'b1;
        first_idx = j;
      end
    end
  end

  // Fold the double-width index back into requester space.
  always_comb begin
    any   = |req_valid;
    grant = (first_idx >= N_REQ) ? SRC_W'(first_idx - N_REQ) : SRC_W'(first_idx);
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// N_REQ:1 round-robin arbiter with a one-entry registered output.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; ready may depend combinationally on valid, valid never waits
// for ready, and data must be held stable while valid is high and not
// accepted on the consumer side.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SRC_W-1:0]       out_src,
  input  logic                   out_ready
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SRC_W-1:0] out_src_q, out_src_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;

  logic [SRC_W-1:0] grant;
  logic             any;
  logic             load;
  logic             accept;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .any       (any)
  );

  // Output register can take a new word when empty or being drained now.
  // Accepting is blocked during reset: the registers are held cleared, so a
  // word granted then would be silently lost.
  always_comb begin
    load   = (state_q == ST_EMPTY) || out_ready;
    accept = load && any && !rst;
  end

  // One-hot ready toward the granted requester only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = accept && (grant == SRC_W'(i));
    end
  end

  // Next-state: reload on accept, drain to EMPTY when nothing is pending.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    ptr_d      = ptr_q;
    if (load) begin
      if (any) begin
        state_d    = ST_FULL;
        out_data_d = req_data[int'(grant)*WIDTH +: WIDTH];
        out_src_d  = grant;
        ptr_d      = SRC_W'(rr_next(32'(grant), 32'(N_REQ)));
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_src_q  <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      ptr_q      <= ptr_d;
    end
  end

  // Output register drives the consumer directly.
  always_comb begin
    out_valid = (state_q == ST_FULL);
    out_data  = out_data_q;
    out_src   = out_src_q;
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed and random stimulus for mux_rr_arbiter with a reference model
// and an expected-output queue holding {src, data} words.
module tb_mux_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = $clog2(N);
  localparam int EW = SW + W;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  int            m_ptr;
  logic [W-1:0]  m_last_data;
  logic [SW-1:0] m_last_src;

  mux_rr_arbiter #(
    .N_REQ (N),
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pick: walk ptr, ptr+1, ... modulo N.
  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [N*W-1:0] ramp_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'(8'hA0 + i);
    return d;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ptr       = 0;
    m_last_data = '0;
    m_last_src  = '0;
  endtask

  // One cycle: drive inputs, check ready, clock, update model, check outputs.
  task automatic step(input logic [N-1:0] v, input logic r);
    logic [N-1:0] exp_rdy;
    logic         load_m;
    logic         any_m;
    int           g;
    req_valid = v;
    out_ready = r;
    #1;
    load_m  = (exp_q.size() == 0) || r;
    any_m   = |v;
    g       = model_pick(v, m_ptr);
    exp_rdy = '0;
    if (load_m && any_m) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    check("ready_implies_valid_load", 32'((req_ready & ~(v & {N{load_m}})) == '0), 32'd1);
    @(posedge clk);
    if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
    if (load_m && any_m) begin
      m_last_data = req_data[g*W +: W];
      m_last_src  = SW'(g);
      exp_q.push_back({m_last_src, m_last_data});
      m_ptr = (g + 1) % N;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_src", 32'(out_src), 32'(exp_q[0][W +: SW]));
      check("out_data", 32'(out_data), 32'(exp_q[0][W-1:0]));
    end else begin
      check("out_data_hold", 32'(out_data), 32'(m_last_data));
      check("out_src_hold", 32'(out_src), 32'(m_last_src));
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = ramp_data();
    out_ready = 1'b0;
    model_reset();

    // Reset state, ready held low even with requests pending.
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    req_valid = '1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Saturation: 0,1,2,3,0,1,2,3 at one word per cycle.
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b1);

    // Load A0, A1, A2 then stall with A2 held for five cycles.
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b0);
    check("stall_data_a2", 32'(out_data), 32'h0000_00A2);
    // Release: requester 3 granted in the same cycle.
    step(4'b1111, 1'b1);
    check("after_stall_src3", 32'(out_src), 32'd3);

    // Sparse and wrap: move ptr to 3 via a grant to 2, then 0101 -> 0 then 2.
    step(4'b0100, 1'b1);
    step(4'b0101, 1'b1);
    check("wrap_src0", 32'(out_src), 32'd0);
    step(4'b0101, 1'b1);
    check("wrap_src2", 32'(out_src), 32'd2);

    // Idle drain: one request for one cycle, then nothing.
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Reset mid-run while FULL.
    step(4'b1111, 1'b0);
    check("pre_rst_full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_src", 32'(out_src), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b1010, 1'b1);
    check("post_rst_grant1", 32'(out_src), 32'd1);

    // Random traffic with random data and backpressure.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom_range(0, 255));
      step(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
